// File: rtl/sdram_sequencer.sv
// sdram_sequencer
//   Command sequencer in front of the SDRAM command/data block. After reset
//   it waits out SDRAM power-up, strobes a mode-register set, then opens the
//   (single, permanently open) row with a bank-activate strobe. It then
//   serves single-word read/write requests from one client over a req/ack
//   handshake. It drives the rising-edge command strobes that the command
//   block edge-detects, and captures read data a fixed delay after a read.
//
// Ports
//   clk_i     in   1   system clock
//   rst_i     in   1   asynchronous active-high reset
//   req_i     in   1   client access request (level)
//   rw_i      in   1   1 = write, 0 = read; sampled on accept
//   addr_i    in  12   column address; sampled on accept
//   wdata_i   in  16   write data; sampled on accept
//   ready_o   out  1   idle, initialised, able to accept
//   ack_o     out  1   one-clock pulse when an access completes
//   rdata_o   out 16   read data, held until the next read completes
//   rvalid_o  out  1   one-clock pulse with ack_o on reads
//   setup_o   out  1   mode-register-set strobe
//   bact_o    out  1   bank-activate strobe
//   we_o      out  1   write strobe (also enables DQ drive downstream)
//   re_o      out  1   read strobe
//   addr_o    out 12   column address to the command block
//   din_o     out 16   write data to the command block
//   dout_i    in  16   registered DQ data from the command block
//
// Every output is a flop whose next value is derived from the next state,
// so each strobe is high exactly while the FSM sits in its strobe state and
// no input reaches an output combinationally.

module sdram_sequencer #(
  parameter int unsigned INIT_CYCLES = 20000,
  parameter int unsigned T_MRD       = 2,
  parameter int unsigned T_RCD       = 3,
  parameter int unsigned STB_LEN     = 2,
  parameter int unsigned RD_DELAY    = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        rw_i,
  input  logic [11:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [15:0] rdata_o,
  output logic        rvalid_o,
  output logic        setup_o,
  output logic        bact_o,
  output logic        we_o,
  output logic        re_o,
  output logic [11:0] addr_o,
  output logic [15:0] din_o,
  input  logic [15:0] dout_i
);

  // Delay counter is wide enough for the power-up wait, never below 15 bits.
  localparam int unsigned CW_REQ = $clog2(INIT_CYCLES + 1);
  localparam int unsigned CW     = (CW_REQ > 15) ? CW_REQ : 15;

  typedef enum logic [3:0] {
    INIT_WAIT,
    MRS,
    MRS_WAIT,
    ACT,
    ACT_WAIT,
    IDLE,
    WR,
    WR_GAP,
    RD,
    RD_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  logic          ready_q, ready_d;
  logic          ack_q, ack_d;
  logic          rvalid_q, rvalid_d;
  logic          setup_q, setup_d;
  logic          bact_q, bact_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic [11:0]   addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [15:0]   rdata_q, rdata_d;

  // State, delay counter and all registered outputs. Reset lands in the
  // power-up wait with the counter preloaded so the wait starts immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= INIT_WAIT;
      cnt_q    <= CW'(INIT_CYCLES - 1);
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      setup_q  <= 1'b0;
      bact_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      setup_q  <= setup_d;
      bact_q   <= bact_d;
      we_q     <= we_d;
      re_q     <= re_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state logic. Each timed state reloads the down-counter with its
  // duration minus one on entry and leaves when it reaches zero. A read
  // loads the full read delay when re rises; that one count both ends the
  // read strobe (after STB_LEN clocks) and times the data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    accept  = 1'b0;
    unique case (state_q)
      INIT_WAIT: begin
        if (cnt_q == '0) begin
          state_d = MRS;
          cnt_d   = CW'(STB_LEN - 1);
        end
      end
      MRS: begin
        if (cnt_q == '0) begin
          state_d = MRS_WAIT;
          cnt_d   = CW'(T_MRD - 1);
        end
      end
      MRS_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACT;
          cnt_d   = CW'(STB_LEN - 1);
        end
      end
      ACT: begin
        if (cnt_q == '0) begin
          state_d = ACT_WAIT;
          cnt_d   = CW'(T_RCD - 1);
        end
      end
      ACT_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (req_i) begin
          accept = 1'b1;
          if (rw_i) begin
            state_d = WR;
            cnt_d   = CW'(STB_LEN - 1);
          end else begin
            state_d = RD;
            cnt_d   = CW'(RD_DELAY - 1);
          end
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          state_d = WR_GAP;
          cnt_d   = '0;
        end
      end
      WR_GAP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      RD: begin
        if (cnt_q == CW'(RD_DELAY - STB_LEN)) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT_WAIT;
        cnt_d   = CW'(INIT_CYCLES - 1);
      end
    endcase
  end

  // Output logic, computed from the next state so the registered outputs
  // line up with the state they belong to. Read data is captured on the
  // edge that enters the last read-wait clock, which is also the clock
  // that carries rvalid/ack.
  always_comb begin
    ready_d  = (state_d == IDLE);
    setup_d  = (state_d == MRS);
    bact_d   = (state_d == ACT);
    we_d     = (state_d == WR);
    re_d     = (state_d == RD);
    rvalid_d = (state_d == RD_WAIT) && (cnt_d == '0);
    ack_d    = (state_d == WR_GAP) || rvalid_d;
    addr_d   = accept ? addr_i : addr_q;
    din_d    = (accept && rw_i) ? wdata_i : din_q;
    rdata_d  = rvalid_d ? dout_i : rdata_q;
  end

  assign ready_o  = ready_q;
  assign ack_o    = ack_q;
  assign rvalid_o = rvalid_q;
  assign setup_o  = setup_q;
  assign bact_o   = bact_q;
  assign we_o     = we_q;
  assign re_o     = re_q;
  assign addr_o   = addr_q;
  assign din_o    = din_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_sdram_sequencer.sv
// tb_sdram_sequencer
//   Directed bench for sdram_sequencer with a shortened power-up wait.
//   Clock k is the k-th clock period after reset release (clock 0 is the
//   period before the first rising edge); outputs are sampled 1 ns after
//   each rising edge and inputs for clock k are driven at the same point.

module tb_sdram_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        rw_i;
  logic [11:0] addr_i;
  logic [15:0] wdata_i;
  logic        ready_o;
  logic        ack_o;
  logic [15:0] rdata_o;
  logic        rvalid_o;
  logic        setup_o;
  logic        bact_o;
  logic        we_o;
  logic        re_o;
  logic [11:0] addr_o;
  logic [15:0] din_o;
  logic [15:0] dout_i;

  int compareCount = 0;
  int failCount    = 0;

  sdram_sequencer #(
    .INIT_CYCLES(10),
    .T_MRD      (2),
    .T_RCD      (3),
    .STB_LEN    (2),
    .RD_DELAY   (6)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .rw_i    (rw_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .ready_o (ready_o),
    .ack_o   (ack_o),
    .rdata_o (rdata_o),
    .rvalid_o(rvalid_o),
    .setup_o (setup_o),
    .bact_o  (bact_o),
    .we_o    (we_o),
    .re_o    (re_o),
    .addr_o  (addr_o),
    .din_o   (din_o),
    .dout_i  (dout_i)
  );

  always #5 clk_i = ~clk_i;

  // Flag vector layout: {setup, bact, we, re, ready, ack, rvalid}.
  localparam logic [6:0] F_SETUP = 7'b1000000;
  localparam logic [6:0] F_BACT  = 7'b0100000;
  localparam logic [6:0] F_WE    = 7'b0010000;
  localparam logic [6:0] F_RE    = 7'b0001000;
  localparam logic [6:0] F_READY = 7'b0000100;
  localparam logic [6:0] F_ACK   = 7'b0000010;
  localparam logic [6:0] F_RVAL  = 7'b0000001;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int k,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s @clock %0d: observed 0x%0h, expected 0x%0h",
             tag, k, observed, expected);
    end
  endtask

  // Init timeline with INIT_CYCLES=10, STB_LEN=2, T_MRD=2, T_RCD=3:
  // setup at 10-11, bact at 14-15, first ready at 19.
  function automatic logic [6:0] initFlags(input int k);
    if (k == 10 || k == 11) return F_SETUP;
    if (k == 14 || k == 15) return F_BACT;
    if (k >= 19)            return F_READY;
    return 7'b0;
  endfunction

  // Main run: write accepted at 19, read at 23, write at 30, idle 34-35,
  // read accepted at 36 and killed by reset at 40.
  function automatic logic [6:0] mainFlags(input int k);
    if (k <= 19)            return initFlags(k);
    if (k == 20 || k == 21) return F_WE;
    if (k == 22)            return F_ACK;
    if (k == 23)            return F_READY;
    if (k == 24 || k == 25) return F_RE;
    if (k >= 26 && k <= 28) return 7'b0;
    if (k == 29)            return F_ACK | F_RVAL;
    if (k == 30)            return F_READY;
    if (k == 31 || k == 32) return F_WE;
    if (k == 33)            return F_ACK;
    if (k >= 34 && k <= 36) return F_READY;
    if (k == 37 || k == 38) return F_RE;
    return 7'b0;
  endfunction

  function automatic logic [11:0] mainAddr(input int k);
    if (k < 20)  return 12'h000;
    if (k <= 23) return 12'h123;
    if (k <= 30) return 12'h045;
    if (k <= 36) return 12'h7FF;
    return 12'h0AA;
  endfunction

  function automatic logic [15:0] mainDin(input int k);
    if (k < 20)  return 16'h0000;
    if (k <= 30) return 16'hBEEF;
    return 16'h1234;
  endfunction

  function automatic logic [15:0] mainRdata(input int k);
    return (k < 29) ? 16'h0000 : 16'h5A5A;
  endfunction

  // Drives the client and DQ inputs for clock k. dout_i carries the read
  // word only during the clock that ends with the capture edge.
  task automatic applyStimulus(input int k, input bit secondInit);
    dout_i = (!secondInit && k == 28) ? 16'h5A5A : 16'hDEAD;
    if (secondInit) begin
      req_i = 1'b0; rw_i = 1'b0; addr_i = 12'h3C3; wdata_i = 16'hC3C3;
    end else if (k <= 19) begin
      req_i = 1'b1; rw_i = 1'b1; addr_i = 12'h123; wdata_i = 16'hBEEF;
    end else if (k <= 29) begin
      req_i = 1'b1; rw_i = 1'b0; addr_i = 12'h045; wdata_i = 16'hFFFF;
    end else if (k == 30) begin
      req_i = 1'b1; rw_i = 1'b1; addr_i = 12'h7FF; wdata_i = 16'h1234;
    end else if (k == 36) begin
      req_i = 1'b1; rw_i = 1'b0; addr_i = 12'h0AA; wdata_i = 16'h5555;
    end else begin
      req_i = 1'b0; rw_i = 1'b1; addr_i = 12'h7FF; wdata_i = 16'h1234;
    end
  endtask

  task automatic checkCycle(input int k, input bit secondInit);
    logic [6:0] flags;
    flags = {setup_o, bact_o, we_o, re_o, ready_o, ack_o, rvalid_o};
    if (secondInit) begin
      checkOutput("flags", k, 32'(flags),   32'(initFlags(k)));
      checkOutput("addr",  k, 32'(addr_o),  32'h0);
      checkOutput("din",   k, 32'(din_o),   32'h0);
      checkOutput("rdata", k, 32'(rdata_o), 32'h0);
    end else begin
      checkOutput("flags", k, 32'(flags),   32'(mainFlags(k)));
      checkOutput("addr",  k, 32'(addr_o),  32'(mainAddr(k)));
      checkOutput("din",   k, 32'(din_o),   32'(mainDin(k)));
      checkOutput("rdata", k, 32'(rdata_o), 32'(mainRdata(k)));
    end
  endtask

  task automatic runPhase(input int fromK, input int toK, input bit secondInit);
    for (int k = fromK; k <= toK; k++) begin
      applyStimulus(k, secondInit);
      checkCycle(k, secondInit);
      tick();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, -1,
                32'({setup_o, bact_o, we_o, re_o, ready_o, ack_o, rvalid_o}),
                32'h0);
    checkOutput({tag, "_addr"},  -1, 32'(addr_o),  32'h0);
    checkOutput({tag, "_din"},   -1, 32'(din_o),   32'h0);
    checkOutput({tag, "_rdata"}, -1, 32'(rdata_o), 32'h0);
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(0, 1'b0);
    tick();
    tick();
    checkAllZero("reset");

    // Release reset 1 ns after an edge: the current period is clock 0.
    rst_i = 1'b0;
    $display("[TB] init with req held high, then write/read/write traffic");
    runPhase(0, 39, 1'b0);

    // Clock 40 is inside the read wait; reset there must clear everything
    // at once and the pending ack (due at clock 42) must never appear.
    applyStimulus(40, 1'b0);
    checkCycle(40, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    checkAllZero("async_reset");
    tick();
    tick();
    tick();
    checkAllZero("held_reset");
    rst_i = 1'b0;

    $display("[TB] init sequence after mid-read reset");
    runPhase(0, 21, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compareCount, failCount);
    $finish;
  end

endmodule
